// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl
// Purpose  : Host-side TX/RX FIFO sequencer in front of the UART tx_rx core.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int TX_GUARD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_wr,
    input  logic [7:0]    host_wdata,
    input  logic          host_rd,
    output logic [7:0]    host_rdata,
    output logic          host_rperr,
    output logic          tx_full,
    output logic          tx_empty,
    output logic          rx_empty,
    output logic [AW:0]   tx_level,
    output logic [AW:0]   rx_level,
    output logic          tx_ovf,
    output logic          rx_ovf,
    input  logic          clr_ovf,
    output logic          write_flag,
    output logic [7:0]    pi_tx_data,
    input  logic          busy_flag,
    input  logic          data_ready,
    input  logic [7:0]    po_rx_data,
    input  logic          parity_error,
    output logic          read_flag
);

    localparam int          GW          = $clog2(TX_GUARD + 1);
    localparam logic [AW:0] C_DEPTH_LVL = (AW + 1)'(DEPTH);
    localparam logic [GW-1:0] C_GUARD_LAST = GW'(TX_GUARD - 1);

    typedef enum logic [1:0] {TX_S_IDLE, TX_S_LAUNCH, TX_S_GUARD, TX_S_WAIT} tx_state_e;
    typedef enum logic [1:0] {RX_S_IDLE, RX_S_ACK, RX_S_HOLD} rx_state_e;

    // ---------------- TX path ----------------
    logic [7:0]    tx_mem_q [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW:0]   tx_level_q, tx_level_d;
    logic          tx_ovf_q, tx_ovf_d;
    tx_state_e     tx_state_q, tx_state_d;
    logic [GW-1:0] guard_cnt_q, guard_cnt_d;
    logic          write_flag_q, write_flag_d;
    logic [7:0]    pi_tx_data_q, pi_tx_data_d;
    logic          tx_push, tx_pop;

    assign tx_full  = (tx_level_q == C_DEPTH_LVL);
    assign tx_empty = (tx_level_q == '0);
    assign tx_pop   = (tx_state_q == TX_S_LAUNCH) && !tx_empty;
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign tx_push  = host_wr && (!tx_full || tx_pop);

    always_comb begin
        tx_wptr_d    = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
        tx_rptr_d    = tx_pop  ? tx_rptr_q + 1'b1 : tx_rptr_q;
        tx_level_d   = tx_level_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_level_d = tx_level_q + 1'b1;
            2'b01:   tx_level_d = tx_level_q - 1'b1;
            default: tx_level_d = tx_level_q;
        endcase
        tx_ovf_d = clr_ovf ? 1'b0 : tx_ovf_q;
        if (host_wr && !tx_push) tx_ovf_d = 1'b1;
    end

    always_comb begin
        tx_state_d   = tx_state_q;
        guard_cnt_d  = guard_cnt_q;
        write_flag_d = 1'b0;
        pi_tx_data_d = pi_tx_data_q;
        case (tx_state_q)
            TX_S_IDLE:   if (!tx_empty && !busy_flag) tx_state_d = TX_S_LAUNCH;
            TX_S_LAUNCH: begin
                write_flag_d = 1'b1;
                pi_tx_data_d = tx_mem_q[tx_rptr_q];
                guard_cnt_d  = '0;
                tx_state_d   = TX_S_GUARD;
            end
            TX_S_GUARD: begin
                if (guard_cnt_q == C_GUARD_LAST) tx_state_d = TX_S_WAIT;
                else                             guard_cnt_d = guard_cnt_q + 1'b1;
            end
            TX_S_WAIT: begin
                // Going straight to LAUNCH keeps back-to-back spacing at TX_GUARD+2.
                if (!busy_flag) tx_state_d = tx_empty ? TX_S_IDLE : TX_S_LAUNCH;
            end
            default: tx_state_d = TX_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= host_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q    <= '0;
            tx_rptr_q    <= '0;
            tx_level_q   <= '0;
            tx_ovf_q     <= 1'b0;
            tx_state_q   <= TX_S_IDLE;
            guard_cnt_q  <= '0;
            write_flag_q <= 1'b0;
            pi_tx_data_q <= '0;
        end else begin
            tx_wptr_q    <= tx_wptr_d;
            tx_rptr_q    <= tx_rptr_d;
            tx_level_q   <= tx_level_d;
            tx_ovf_q     <= tx_ovf_d;
            tx_state_q   <= tx_state_d;
            guard_cnt_q  <= guard_cnt_d;
            write_flag_q <= write_flag_d;
            pi_tx_data_q <= pi_tx_data_d;
        end
    end

    assign tx_level   = tx_level_q;
    assign tx_ovf     = tx_ovf_q;
    assign write_flag = write_flag_q;
    assign pi_tx_data = pi_tx_data_q;

    // ---------------- RX path ----------------
    logic [8:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [AW:0]   rx_level_q, rx_level_d;
    logic          rx_ovf_q, rx_ovf_d;
    rx_state_e     rx_state_q, rx_state_d;
    logic          rx_full, rx_push, rx_pop, rx_ack;
    logic [8:0]    rx_head;

    assign rx_full  = (rx_level_q == C_DEPTH_LVL);
    assign rx_empty = (rx_level_q == '0);
    assign rx_ack   = (rx_state_q == RX_S_ACK);
    assign rx_pop   = host_rd && !rx_empty;
    assign rx_push  = rx_ack && (!rx_full || rx_pop);

    always_comb begin
        rx_wptr_d  = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
        rx_rptr_d  = rx_pop  ? rx_rptr_q + 1'b1 : rx_rptr_q;
        rx_level_d = rx_level_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_level_d = rx_level_q + 1'b1;
            2'b01:   rx_level_d = rx_level_q - 1'b1;
            default: rx_level_d = rx_level_q;
        endcase
        rx_ovf_d = clr_ovf ? 1'b0 : rx_ovf_q;
        if (rx_ack && !rx_push) rx_ovf_d = 1'b1;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_S_IDLE: if (data_ready) rx_state_d = RX_S_ACK;
            RX_S_ACK:  rx_state_d = RX_S_HOLD;
            RX_S_HOLD: rx_state_d = RX_S_IDLE;
            default:   rx_state_d = RX_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= {parity_error, po_rx_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            rx_ovf_q   <= 1'b0;
            rx_state_q <= RX_S_IDLE;
        end else begin
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_level_q <= rx_level_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_state_q <= rx_state_d;
        end
    end

    // Head is masked while empty so stale or uninitialised storage never shows.
    assign rx_head    = rx_empty ? 9'd0 : rx_mem_q[rx_rptr_q];
    assign host_rdata = rx_head[7:0];
    assign host_rperr = rx_head[8];
    assign rx_level   = rx_level_q;
    assign rx_ovf     = rx_ovf_q;
    assign read_flag  = rx_ack;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_ctrl
// Purpose  : Scoreboard bench for uart_fifo_ctrl with a simple tx_rx model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_wr, host_rd, clr_ovf;
    logic [7:0] host_wdata, host_rdata;
    logic       host_rperr, tx_full, tx_empty, rx_empty, tx_ovf, rx_ovf;
    logic [4:0] tx_level, rx_level;
    logic       write_flag, read_flag;
    logic [7:0] pi_tx_data, po_rx_data;
    logic       busy_flag = 1'b0;
    logic       data_ready, parity_error;

    int n_cmp = 0;
    int n_err = 0;
    int n_launch = 0;
    int n_ack = 0;
    int busy_mode = 0;
    int busy_cnt = 0;
    logic [7:0] exp_tx[$];
    logic [8:0] exp_rx[$];

    always #5 clk = ~clk;

    uart_fifo_ctrl #(.DEPTH(16), .AW(4), .TX_GUARD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_wr(host_wr), .host_wdata(host_wdata),
        .host_rd(host_rd), .host_rdata(host_rdata), .host_rperr(host_rperr),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_empty(rx_empty),
        .tx_level(tx_level), .rx_level(rx_level),
        .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .clr_ovf(clr_ovf),
        .write_flag(write_flag), .pi_tx_data(pi_tx_data),
        .busy_flag(busy_flag), .data_ready(data_ready),
        .po_rx_data(po_rx_data), .parity_error(parity_error),
        .read_flag(read_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_launch(input int target, input int budget);
        for (int k = 0; k < budget && n_launch < target; k++) tick();
        check("launch_count", 32'(n_launch), 32'(target));
    endtask

    // tx_rx stand-in: hands over one byte and waits for the acknowledge.
    task automatic deliver(input logic [7:0] d, input logic pe);
        int k;
        po_rx_data   = d;
        parity_error = pe;
        data_ready   = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (read_flag) break;
        end
        if (k == 20) fail_now("rx_ack_timeout");
        data_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor plus busy model, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (write_flag) begin
                n_launch++;
                check("busy_low_at_launch", 32'(busy_flag), 32'd0);
                if (exp_tx.size() == 0) fail_now("tx_unexpected_launch");
                else check("tx_byte", 32'(pi_tx_data), 32'(exp_tx.pop_front()));
            end
            if (read_flag) n_ack++;
            if (host_rd && !rx_empty) begin
                if (exp_rx.size() == 0) fail_now("rx_unexpected_pop");
                else check("rx_head", 32'({host_rperr, host_rdata}), 32'(exp_rx.pop_front()));
            end
        end
        if (busy_mode == 2) begin
            busy_flag = 1'b1;
        end else if (busy_mode == 1) begin
            if (rst_n && write_flag) busy_cnt = 20;
            else if (busy_cnt > 0)   busy_cnt--;
            busy_flag = (busy_cnt > 0);
        end else begin
            busy_cnt  = 0;
            busy_flag = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] t2v [3];
        t2v = '{8'h11, 8'h22, 8'h33};
        rst_n = 1'b0; host_wr = 1'b0; host_wdata = '0; host_rd = 1'b0; clr_ovf = 1'b0;
        data_ready = 1'b0; po_rx_data = '0; parity_error = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_tx_empty", 32'(tx_empty), 1);
        check("rst_rx_empty", 32'(rx_empty), 1);
        check("rst_levels", 32'({tx_level, rx_level}), 0);
        check("rst_flags", 32'({write_flag, read_flag, tx_full, tx_ovf, rx_ovf}), 0);
        check("rst_data", 32'({pi_tx_data, host_rdata, host_rperr}), 0);

        // single byte, idle transmitter
        host_wr = 1'b1; host_wdata = 8'hA5; exp_tx.push_back(8'hA5);
        tick();
        host_wr = 1'b0;
        check("t1_level_after_push", 32'(tx_level), 1);
        tick();
        check("t1_flag_not_yet", 32'(write_flag), 0);
        tick();
        check("t1_write_flag", 32'(write_flag), 1);
        check("t1_pi_tx_data", 32'(pi_tx_data), 32'h A5);
        check("t1_tx_empty", 32'(tx_empty), 1);
        tick();
        check("t1_pulse_width", 32'(write_flag), 0);
        repeat (10) tick();

        // three bytes, 20-cycle busy per launch
        busy_mode = 1;
        base = n_launch;
        for (int i = 0; i < 3; i++) begin
            host_wr = 1'b1; host_wdata = t2v[i]; exp_tx.push_back(t2v[i]);
            tick();
        end
        host_wr = 1'b0;
        wait_launch(base + 3, 300);
        repeat (30) tick();
        check("t2_tx_empty", 32'(tx_empty), 1);

        // overfill with transmitter held busy
        busy_mode = 2;
        repeat (2) tick();
        base = n_launch;
        for (int i = 0; i < 17; i++) begin
            host_wr = 1'b1; host_wdata = 8'h40 + 8'(i);
            if (i < 16) exp_tx.push_back(8'h40 + 8'(i));
            tick();
        end
        host_wr = 1'b0;
        check("t3_tx_full", 32'(tx_full), 1);
        check("t3_tx_level", 32'(tx_level), 16);
        check("t3_tx_ovf", 32'(tx_ovf), 1);
        check("t3_no_launch", 32'(n_launch), 32'(base));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_ovf_cleared", 32'(tx_ovf), 0);
        check("t3_level_kept", 32'(tx_level), 16);
        busy_mode = 1;
        wait_launch(base + 16, 1500);
        repeat (30) tick();
        check("t3_drained", 32'(tx_empty), 1);

        // single received byte with parity error
        base = n_ack;
        exp_rx.push_back({1'b1, 8'h5C});
        deliver(8'h5C, 1'b1);
        check("t4_ack_count", 32'(n_ack), 32'(base + 1));
        check("t4_rx_level", 32'(rx_level), 1);
        check("t4_rdata", 32'(host_rdata), 32'h5C);
        check("t4_rperr", 32'(host_rperr), 1);
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        check("t4_rx_empty", 32'(rx_empty), 1);

        // overfill RX, then push+pop at full
        base = n_ack;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_rx.push_back({1'(i % 2), 8'h80 + 8'(i)});
            deliver(8'h80 + 8'(i), 1'(i % 2));
        end
        check("t5_ack_count", 32'(n_ack), 32'(base + 17));
        check("t5_rx_level", 32'(rx_level), 16);
        check("t5_rx_ovf", 32'(rx_ovf), 1);
        check("t5_head", 32'({host_rperr, host_rdata}), 32'h080);
        repeat (2) tick();
        po_rx_data = 8'h99; parity_error = 1'b1; data_ready = 1'b1;
        exp_rx.push_back({1'b1, 8'h99});
        tick();
        check("t5_ack_state", 32'(read_flag), 1);
        host_rd = 1'b1; data_ready = 1'b0;
        tick();
        host_rd = 1'b0;
        check("t5_level_full_pushpop", 32'(rx_level), 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t5_rx_ovf_cleared", 32'(rx_ovf), 0);
        for (int i = 0; i < 16; i++) begin
            host_rd = 1'b1;
            tick();
        end
        host_rd = 1'b0;
        check("t5_rx_drained", 32'(rx_empty), 1);

        // reset while waiting on the transmitter with bytes queued
        busy_mode = 1;
        base = n_launch;
        exp_tx.push_back(8'h60);
        for (int i = 0; i < 6; i++) begin
            host_wr = 1'b1; host_wdata = 8'h60 + 8'(i);
            tick();
        end
        host_wr = 1'b0;
        wait_launch(base + 1, 50);
        repeat (8) tick();
        check("t6_queued", 32'(tx_level), 5);
        rst_n = 1'b0;
        #1;
        check("t6_rst_level", 32'(tx_level), 0);
        check("t6_rst_flag", 32'(write_flag), 0);
        busy_mode = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("t6_no_relaunch", 32'(n_launch), 32'(base + 1));
        host_wr = 1'b1; host_wdata = 8'h77; exp_tx.push_back(8'h77);
        tick();
        host_wr = 1'b0;
        wait_launch(base + 2, 50);
        repeat (5) tick();

        check("tx_scoreboard_empty", 32'(exp_tx.size()), 0);
        check("rx_scoreboard_empty", 32'(exp_rx.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
